traffic_lamp_monitor: RTL and testbench

Receive-side checker for the intersection lamp bus. It samples the car lamp code (4-bit one-hot) and the walker lamp code (2-bit) driven by the traffic controller, and decodes them into a phase state machine. It measures phase lengths, detects illegal codes, conflicts, sequence errors and stuck lamps, and reports the first fault stickily. It sits beside the controller on the same `i_start` enable and drives the status/diagnostic interface.

---
 rtl/traffic_lamp_monitor.sv | 149 ++++++++++++++
 tb/tb_traffic_lamp_monitor.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_lamp_monitor.sv
// Receive-side checker for the intersection lamp bus: decodes the car/walker
// lamp codes into a phase FSM, times each phase and latches the first fault.
module traffic_lamp_monitor #(
    parameter int YELLOW_LEN  = 2,
    parameter int STUCK_LIMIT = 40,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_start,
    input  logic [3:0]       i_car_traffic,
    input  logic [1:0]       i_walker_traffic,
    input  logic             i_fault_clr,
    output logic [2:0]       o_phase,
    output logic [6:0]       o_phase_cnt,
    output logic             o_cycle_done,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic             o_fault,
    output logic [2:0]       o_fault_code
);

    localparam logic [2:0] PH_IDLE  = 3'd0;
    localparam logic [2:0] PH_RED   = 3'd1;
    localparam logic [2:0] PH_GREEN = 3'd2;
    localparam logic [2:0] PH_Y1    = 3'd3;
    localparam logic [2:0] PH_LEFT  = 3'd4;
    localparam logic [2:0] PH_Y2    = 3'd5;

    localparam logic [3:0] CAR_RED  = 4'b1000;
    localparam logic [3:0] CAR_YEL  = 4'b0100;
    localparam logic [3:0] CAR_LEFT = 4'b0010;
    localparam logic [3:0] CAR_GRN  = 4'b0001;

    logic [2:0]       phase_q, phase_d;
    logic [6:0]       cnt_q, cnt_d, cnt_inc;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic             fault_q, fault_d;
    logic [2:0]       code_q, code_d;

    logic       illegal, conflict, bad_seq, yel_err, stuck;
    logic       same_code, seq_ok, is_yellow;
    logic [2:0] seq_phase, resync_phase, det_code;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            cyc_q   <= '0;
            fault_q <= 1'b0;
            code_q  <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            cyc_q   <= cyc_d;
            fault_q <= fault_d;
            code_q  <= code_d;
        end
    end

    // Next phase: hold while the code matches, follow the legal sequence,
    // otherwise resync to whatever the lamps show (yellow resyncs to Y1).
    always_comb begin
        illegal   = !(i_car_traffic inside {CAR_RED, CAR_YEL, CAR_LEFT, CAR_GRN})
                    || (i_walker_traffic == 2'b11);
        conflict  = (i_car_traffic != CAR_RED)
                    && (i_walker_traffic == 2'b01 || i_walker_traffic == 2'b00);
        is_yellow = (phase_q == PH_Y1) || (phase_q == PH_Y2);
        cnt_inc   = (cnt_q == 7'd127) ? cnt_q : cnt_q + 7'd1;

        case (i_car_traffic)
            CAR_RED:  resync_phase = PH_RED;
            CAR_GRN:  resync_phase = PH_GREEN;
            CAR_LEFT: resync_phase = PH_LEFT;
            default:  resync_phase = PH_Y1;
        endcase

        same_code = 1'b0;
        seq_ok    = 1'b0;
        seq_phase = resync_phase;
        case (phase_q)
            PH_IDLE:  seq_ok = (i_car_traffic == CAR_RED) || (i_car_traffic == CAR_GRN);
            PH_RED:   begin same_code = (i_car_traffic == CAR_RED);  seq_ok = (i_car_traffic == CAR_GRN);  seq_phase = PH_GREEN; end
            PH_GREEN: begin same_code = (i_car_traffic == CAR_GRN);  seq_ok = (i_car_traffic == CAR_YEL);  seq_phase = PH_Y1;    end
            PH_Y1:    begin same_code = (i_car_traffic == CAR_YEL);  seq_ok = (i_car_traffic == CAR_LEFT); seq_phase = PH_LEFT;  end
            PH_LEFT:  begin same_code = (i_car_traffic == CAR_LEFT); seq_ok = (i_car_traffic == CAR_YEL);  seq_phase = PH_Y2;    end
            PH_Y2:    begin same_code = (i_car_traffic == CAR_YEL);  seq_ok = (i_car_traffic == CAR_RED);  seq_phase = PH_RED;   end
            default:  seq_ok = 1'b0;
        endcase

        phase_d = phase_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        bad_seq = 1'b0;
        yel_err = 1'b0;
        stuck   = 1'b0;
        if (!i_start) begin
            phase_d = PH_IDLE;
            cnt_d   = '0;
        end else if (!illegal) begin
            if (same_code) begin
                cnt_d   = cnt_inc;
                yel_err = is_yellow && (int'(cnt_inc) == YELLOW_LEN + 1);
                stuck   = (int'(cnt_inc) == STUCK_LIMIT + 1);
            end else begin
                phase_d = seq_ok ? seq_phase : resync_phase;
                cnt_d   = 7'd1;
                bad_seq = !seq_ok;
                yel_err = is_yellow && (int'(cnt_q) < YELLOW_LEN);
                done_d  = (phase_q == PH_Y2) && seq_ok;
            end
        end
    end

    // Fault latch: lowest code wins within a sample; a fresh detection
    // overrides a simultaneous clear. Everything is held while disabled.
    always_comb begin
        det_code = 3'd0;
        if (i_start) begin
            if (illegal)       det_code = 3'd1;
            else if (conflict) det_code = 3'd2;
            else if (bad_seq)  det_code = 3'd3;
            else if (yel_err)  det_code = 3'd4;
            else if (stuck)    det_code = 3'd5;
        end

        fault_d = fault_q;
        code_d  = code_q;
        if (i_start && i_fault_clr) begin
            fault_d = (det_code != 3'd0);
            code_d  = det_code;
        end else if (!fault_q && det_code != 3'd0) begin
            fault_d = 1'b1;
            code_d  = det_code;
        end

        cyc_d = cyc_q + CNT_W'(done_d);

        o_phase      = phase_q;
        o_phase_cnt  = cnt_q;
        o_cycle_done = done_q;
        o_cycle_cnt  = cyc_q;
        o_fault      = fault_q;
        o_fault_code = code_q;
    end

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Bench for traffic_lamp_monitor: directed lamp scenarios with literal
// expectations, then randomized lamp sequences against a phase-table model.
module tb_traffic_lamp_monitor;

    localparam int YL = 2;
    localparam int SL = 40;
    localparam int CW = 16;
    localparam int W  = 3 + 7 + 1 + CW + 1 + 3;

    localparam logic [3:0] C_RED = 4'b1000, C_YEL = 4'b0100, C_LEFT = 4'b0010, C_GRN = 4'b0001;
    localparam logic [1:0] W_RED = 2'b10, W_GRN = 2'b01, W_NONE = 2'b00;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          i_start = 1'b0;
    logic [3:0]    i_car_traffic = 4'b0;
    logic [1:0]    i_walker_traffic = 2'b0;
    logic          i_fault_clr = 1'b0;
    logic [2:0]    o_phase;
    logic [6:0]    o_phase_cnt;
    logic          o_cycle_done;
    logic [CW-1:0] o_cycle_cnt;
    logic          o_fault;
    logic [2:0]    o_fault_code;

    traffic_lamp_monitor #(.YELLOW_LEN(YL), .STUCK_LIMIT(SL), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start),
        .i_car_traffic(i_car_traffic), .i_walker_traffic(i_walker_traffic),
        .i_fault_clr(i_fault_clr), .o_phase(o_phase), .o_phase_cnt(o_phase_cnt),
        .o_cycle_done(o_cycle_done), .o_cycle_cnt(o_cycle_cnt),
        .o_fault(o_fault), .o_fault_code(o_fault_code)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    // Phase table: lamp code shown in each phase, sequence successor by index.
    logic [3:0] ph_code [6] = '{4'b0000, C_RED, C_GRN, C_YEL, C_LEFT, C_YEL};
    int            m_phase = 0, m_cnt = 0, m_nxt, m_newp, m_det;
    logic          m_done = 1'b0, m_fault = 1'b0;
    logic [CW-1:0] m_cyc = '0;
    logic [2:0]    m_code = '0;
    bit            m_ill, m_conf, m_bad, m_yel, m_stk, m_ok;

    function automatic int resync(input logic [3:0] car);
        if (car == C_RED) return 1;
        if (car == C_GRN) return 2;
        if (car == C_LEFT) return 4;
        return 3;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            m_phase = 0; m_cnt = 0; m_done = 0; m_cyc = '0; m_fault = 0; m_code = '0;
        end else if (!i_start) begin
            m_phase = 0; m_cnt = 0; m_done = 0;
        end else begin
            m_done = 0; m_bad = 0; m_yel = 0; m_stk = 0;
            m_ill  = !(i_car_traffic inside {C_RED, C_YEL, C_LEFT, C_GRN}) || i_walker_traffic == 2'b11;
            m_conf = i_car_traffic != C_RED && i_walker_traffic inside {W_GRN, W_NONE};
            if (!m_ill) begin
                if (m_phase != 0 && i_car_traffic == ph_code[m_phase]) begin
                    if (m_cnt < 127) m_cnt = m_cnt + 1;
                    m_yel = (m_phase == 3 || m_phase == 5) && m_cnt == YL + 1;
                    m_stk = m_cnt == SL + 1;
                end else begin
                    if (m_phase == 0) begin
                        m_ok = i_car_traffic == C_RED || i_car_traffic == C_GRN;
                        m_newp = resync(i_car_traffic);
                    end else begin
                        m_nxt = m_phase % 5 + 1;
                        m_ok = ph_code[m_nxt] == i_car_traffic;
                        m_newp = m_ok ? m_nxt : resync(i_car_traffic);
                    end
                    m_yel = (m_phase == 3 || m_phase == 5) && m_cnt < YL;
                    m_done = m_phase == 5 && m_newp == 1;
                    if (m_done) m_cyc = m_cyc + 1'b1;
                    m_bad = !m_ok;
                    m_phase = m_newp;
                    m_cnt = 1;
                end
            end
            m_det = m_ill ? 1 : m_conf ? 2 : m_bad ? 3 : m_yel ? 4 : m_stk ? 5 : 0;
            if (i_fault_clr) begin
                m_fault = m_det != 0; m_code = 3'(m_det);
            end else if (!m_fault && m_det != 0) begin
                m_fault = 1; m_code = 3'(m_det);
            end
        end
        exp_q.push_back({3'(m_phase), 7'(m_cnt), m_done, m_cyc, m_fault, m_code});
    end

    logic [W-1:0] exp_v, act_v;
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            act_v = {o_phase, o_phase_cnt, o_cycle_done, o_cycle_cnt, o_fault, o_fault_code};
            n_vec++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL model_cmp t=%0t got phase=%0d cnt=%0d done=%0b cyc=%0d fault=%0b code=%0d expected phase=%0d cnt=%0d done=%0b cyc=%0d fault=%0b code=%0d",
                         $time, act_v[W-1 -: 3], act_v[W-4 -: 7], act_v[W-11], act_v[W-12 -: CW], act_v[3], act_v[2:0],
                         exp_v[W-1 -: 3], exp_v[W-4 -: 7], exp_v[W-11], exp_v[W-12 -: CW], exp_v[3], exp_v[2:0]);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] car, input logic [1:0] walk, input logic st, input logic clr);
        i_car_traffic = car; i_walker_traffic = walk; i_start = st; i_fault_clr = clr;
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [3:0] seq_car [5] = '{C_RED, C_GRN, C_YEL, C_LEFT, C_YEL};
    int pos, r, dur;
    logic [1:0] walk;

    initial begin
        step(C_RED, W_RED, 0, 0);
        step(C_RED, W_RED, 0, 0);
        chk("reset_phase", o_phase, 0);
        chk("reset_fault", o_fault, 0);
        reset_n = 1'b1;

        // nominal cycle
        repeat (21) step(C_GRN, W_RED, 1, 0);
        chk("nom_green_phase", o_phase, 2);
        chk("nom_green_cnt", o_phase_cnt, 21);
        step(C_YEL, W_RED, 1, 0);
        chk("nom_y1_phase", o_phase, 3);
        step(C_YEL, W_RED, 1, 0);
        step(C_LEFT, W_RED, 1, 0);
        chk("nom_left_phase", o_phase, 4);
        repeat (9) step(C_LEFT, W_RED, 1, 0);
        step(C_YEL, W_RED, 1, 0);
        chk("nom_y2_phase", o_phase, 5);
        step(C_YEL, W_RED, 1, 0);
        step(C_RED, W_GRN, 1, 0);
        chk("nom_red_phase", o_phase, 1);
        chk("nom_cycle_done", o_cycle_done, 1);
        chk("nom_cycle_cnt", o_cycle_cnt, 1);
        for (int i = 0; i < 33; i++) step(C_RED, (i % 2) ? W_GRN : W_NONE, 1, 0);
        chk("nom_done_once", o_cycle_done, 0);
        chk("nom_red_cnt", o_phase_cnt, 34);
        chk("nom_no_fault", o_fault, 0);

        // conflict
        step(C_GRN, W_GRN, 1, 0);
        chk("conflict_fault", o_fault, 1);
        chk("conflict_code", o_fault_code, 2);
        step(C_GRN, W_RED, 1, 1);
        chk("clr_fault", o_fault, 0);

        // yellow too long
        step(C_YEL, W_RED, 1, 0);
        step(C_YEL, W_RED, 1, 0);
        chk("yel2_no_fault", o_fault, 0);
        step(C_YEL, W_RED, 1, 0);
        chk("yel_long_code", o_fault_code, 4);

        // idle holds the fault
        step(C_YEL, W_RED, 0, 0);
        step(C_YEL, W_RED, 0, 0);
        chk("idle_phase", o_phase, 0);
        chk("idle_cnt", o_phase_cnt, 0);
        chk("idle_fault_held", o_fault_code, 4);

        // bad sequence
        step(C_GRN, W_RED, 1, 1);
        chk("reentry_phase", o_phase, 2);
        chk("reentry_clr", o_fault, 0);
        step(C_LEFT, W_RED, 1, 0);
        chk("badseq_code", o_fault_code, 3);
        chk("badseq_phase", o_phase, 4);
        chk("badseq_cnt", o_phase_cnt, 1);
        step(C_LEFT, W_RED, 1, 1);

        // illegal code and priority
        step(4'b0011, W_RED, 1, 0);
        chk("illegal_code", o_fault_code, 1);
        chk("illegal_hold_cnt", o_phase_cnt, 2);
        step(C_LEFT, W_RED, 1, 1);
        chk("illegal_clr", o_fault, 0);
        step(4'b0011, W_GRN, 1, 0);
        chk("priority_code", o_fault_code, 1);
        step(C_LEFT, W_RED, 1, 1);

        // stuck then reset
        step(C_YEL, W_RED, 1, 0);
        step(C_YEL, W_RED, 1, 0);
        step(C_RED, W_RED, 1, 0);
        chk("second_cycle_cnt", o_cycle_cnt, 2);
        repeat (39) step(C_RED, W_RED, 1, 0);
        chk("red40_no_fault", o_fault, 0);
        step(C_RED, W_RED, 1, 0);
        chk("stuck_code", o_fault_code, 5);
        reset_n = 1'b0;
        step(C_RED, W_RED, 1, 0);
        chk("rst_phase", o_phase, 0);
        chk("rst_code", o_fault_code, 0);
        chk("rst_cyc", o_cycle_cnt, 0);
        reset_n = 1'b1;

        // randomized lamp sequences
        pos = 0;
        for (int seg = 0; seg < 300; seg++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                repeat ($urandom_range(1, 3)) step(seq_car[pos], W_RED, 0, 0);
                pos = $urandom_range(0, 1);
            end else if (r == 1) begin
                step(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1, 0);
                continue;
            end else if (r == 2) begin
                pos = $urandom_range(0, 4);
            end else begin
                pos = (pos + 1) % 5;
            end
            if (pos == 2 || pos == 4) dur = $urandom_range(1, 3);
            else if (r == 3) dur = $urandom_range(38, 44);
            else dur = $urandom_range(1, 6);
            for (int k = 0; k < dur; k++) begin
                walk = (pos == 0) ? 2'($urandom_range(0, 2)) : W_RED;
                if ($urandom_range(0, 20) == 0) walk = W_GRN;
                step(seq_car[pos], walk, 1, $urandom_range(0, 25) == 0);
            end
        end

        step(C_RED, W_RED, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
